uart_rx: RTL and testbench

- UART receiver consuming the 16x oversampling `baud_tick` from the baud-rate generator.
- Synchronizes the asynchronous `rx` line, detects and validates the start bit, and samples data bits LSB-first at mid-bit.
- Checks the stop bit and presents each byte on a valid/ready interface to the register/FIFO layer above.
- Flags framing and overrun errors.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants,
// common to uart_rx and the future uart_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned OVERSAMPLE  = 16;
    localparam int unsigned MID_SAMPLE  = 7;
    localparam int unsigned LAST_SAMPLE = 15;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the async rx line plus a falling-edge detector.
// All flops reset to the idle-high line level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic rx,
    output logic line,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic prev;

    // prev advances only on oversample ticks, so an edge landing between
    // ticks is still seen as prev=1/cur=0 on the next tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            if (sample_en) prev <= sync2;
        end
    end

    assign line = sync2;
    assign fall = prev & ~sync2;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with valid/ready output and error pulses.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       baud_tick,
    input  logic       rx,
    input  logic       parity_odd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       parity_err,
    output logic       busy
);

    import uart_pkg::*;

    localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_e state, state_d;
    logic [3:0]  tick_cnt, tick_cnt_d;
    logic [2:0]  bit_idx, bit_idx_d;
    logic [7:0]  shift, shift_d;
    logic [7:0]  data_word;
    logic        adv;
    logic        line;
    logic        fall;
    logic        stop_sample;
    logic        commit;
    logic        stop_bad;

    assign adv       = en & baud_tick;
    assign data_word = shift >> (8 - DATA_BITS);
    assign busy      = (state != IDLE);

    uart_rx_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .sample_en (adv),
        .rx        (rx),
        .line      (line),
        .fall      (fall)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bit, par_bit_d;
    logic par_bad;

    assign par_bad = par_bit ^ (^data_word) ^ parity_odd;
`endif

    always_comb begin
        state_d     = state;
        tick_cnt_d  = tick_cnt;
        bit_idx_d   = bit_idx;
        shift_d     = shift;
        stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d   = par_bit;
`endif
        if (!en) begin
            state_d = IDLE;
        end else if (baud_tick) begin
            case (state)
                IDLE: begin
                    if (fall) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end
                START: begin
                    if (tick_cnt == MID_TICK) begin
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                        state_d    = line ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt + 4'd1;
                    end
                end
                DATA: begin
                    tick_cnt_d = tick_cnt + 4'd1;
                    if (tick_cnt == LAST_TICK) begin
                        shift_d    = {line, shift[7:1]};
                        tick_cnt_d = '0;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_idx_d = bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    tick_cnt_d = tick_cnt + 4'd1;
                    if (tick_cnt == LAST_TICK) begin
                        par_bit_d  = line;
                        tick_cnt_d = '0;
                        state_d    = STOP;
                    end
                end
`endif
                STOP: begin
                    tick_cnt_d = tick_cnt + 4'd1;
                    if (tick_cnt == LAST_TICK) begin
                        stop_sample = 1'b1;
                        tick_cnt_d  = '0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign commit   = stop_sample & line;
    assign stop_bad = stop_sample & ~line;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state       <= state_d;
            tick_cnt    <= tick_cnt_d;
            bit_idx     <= bit_idx_d;
            shift       <= shift_d;
            frame_err   <= stop_bad;
            // A commit coinciding with a handshake replaces the consumed byte.
            overrun_err <= commit & rx_valid & ~rx_ready;
            if (commit) begin
                rx_data  <= data_word;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bit    <= par_bit_d;
            parity_err <= stop_sample & par_bad;
        end
    end
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
    assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx against a frame-level reference model.
module tb_uart_rx;

    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = 16 * TICK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam bit HAS_PAR = (FRAME_BITS == 11);
    // edge caught one tick after drive, stop sampled mid-bit, +1 register stage
    localparam int LATENCY = TICK_DIV + TICK_DIV * (8 + 16 * (FRAME_BITS - 1)) + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic       parity_odd = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun_err;
    logic       parity_err;
    logic       busy;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .baud_tick   (baud_tick),
        .rx          (rx),
        .parity_odd  (parity_odd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int n_ferr = 0;
    int n_oerr = 0;
    int n_perr = 0;
    logic [7:0] m_data = '0;
    logic       m_valid = 1'b0;
    logic       saw_busy;
    int         vat;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One clock: sample pulse outputs at negedge, then set up the next tick.
    task automatic step();
        @(negedge clk);
        if (frame_err)   n_ferr++;
        if (overrun_err) n_oerr++;
        if (parity_err)  n_perr++;
        if (busy)        saw_busy = 1'b1;
        cyc++;
        baud_tick = (cyc % TICK_DIV == 0);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    function automatic logic good_par(input logic [7:0] b);
        return (^b) ^ parity_odd;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit,
                              input int ready_at, input int abort_at, output int valid_at);
        logic [FRAME_BITS-1:0] bits;
        logic was_valid;
        int k;
        bits = '0;
        bits[8:1] = b;
        if (HAS_PAR) bits[9] = par_bit;
        bits[FRAME_BITS-1] = stop_bit;
        k = 0;
        valid_at = -1;
        while (cyc % TICK_DIV != 0) step();
        was_valid = rx_valid;
        for (int i = 0; i < FRAME_BITS; i++) begin
            rx = bits[i];
            for (int j = 0; j < BIT_CLKS; j++) begin
                if (k == abort_at) return;
                if (ready_at >= 0) rx_ready = (k == ready_at);
                step();
                k++;
                if (valid_at < 0 && !was_valid && rx_valid) valid_at = k;
            end
        end
        rx = 1'b1;
        if (ready_at >= 0) rx_ready = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit,
                             input logic hs, output int valid_at);
        int f0, o0, p0;
        logic exp_o, exp_p;
        f0 = n_ferr; o0 = n_oerr; p0 = n_perr;
        exp_o = stop_bit && m_valid && !hs;
        exp_p = HAS_PAR && (par_bit != good_par(b));
        send_frame(b, stop_bit, par_bit, hs ? LATENCY - 1 : -1, -1, valid_at);
        if (stop_bit) begin
            m_data  = b;
            m_valid = 1'b1;
        end
        check_eq("frame_err", 32'(n_ferr - f0), {31'd0, !stop_bit});
        check_eq("overrun_err", 32'(n_oerr - o0), {31'd0, exp_o});
        check_eq("parity_err", 32'(n_perr - p0), {31'd0, exp_p});
        check_eq("rx_valid", {31'd0, rx_valid}, {31'd0, m_valid});
        check_eq("rx_data", {24'd0, rx_data}, {24'd0, m_data});
        check_eq("busy_after", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_read();
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        m_valid = 1'b0;
        step();
        check_eq("read_clears", {31'd0, rx_valid}, 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        logic       sb;
        int         f0;

        steps(5);
        check_eq("rst_data", {24'd0, rx_data}, 32'd0);
        check_eq("rst_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_errs", {29'd0, frame_err, overrun_err, parity_err}, 32'd0);
        rst = 1'b1;
        en  = 1'b1;
        steps(8);

        // 0xA5 with latency measured from the start-edge drive
        run_frame(8'hA5, 1'b1, good_par(8'hA5), 1'b0, vat);
        check_eq("latency", 32'(vat), 32'(LATENCY));
        do_read();

        // overrun: two frames without reading
        run_frame(8'h3C, 1'b1, good_par(8'h3C), 1'b0, vat);
        run_frame(8'hC3, 1'b1, good_par(8'hC3), 1'b0, vat);
        do_read();

        // handshake in the commit cycle avoids overrun
        run_frame(8'h3C, 1'b1, good_par(8'h3C), 1'b0, vat);
        run_frame(8'hC3, 1'b1, good_par(8'hC3), 1'b1, vat);
        do_read();

        // framing error, then line held low must not retrigger
        run_frame(8'h55, 1'b0, good_par(8'h55), 1'b0, vat);
        rx = 1'b0;
        f0 = n_ferr;
        saw_busy = 1'b0;
        steps(40 * TICK_DIV);
        check_eq("low_no_retrigger", {31'd0, saw_busy}, 32'd0);
        check_eq("low_no_err", 32'(n_ferr - f0), 32'd0);
        rx = 1'b1;
        steps(BIT_CLKS);
        run_frame(8'h5A, 1'b1, good_par(8'h5A), 1'b0, vat);
        do_read();

        // 3-tick glitch is rejected at mid start bit
        while (cyc % TICK_DIV != 0) step();
        f0 = n_ferr;
        saw_busy = 1'b0;
        rx = 1'b0;
        steps(3 * TICK_DIV);
        rx = 1'b1;
        steps(40 * TICK_DIV);
        check_eq("glitch_busy_seen", {31'd0, saw_busy}, 32'd1);
        check_eq("glitch_idle", {31'd0, busy}, 32'd0);
        check_eq("glitch_no_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("glitch_no_err", 32'(n_ferr - f0), 32'd0);

        // en dropped after data bit 3 of 0xFF
        send_frame(8'hFF, 1'b1, good_par(8'hFF), -1, 5 * BIT_CLKS, vat);
        en = 1'b0;
        step();
        check_eq("en_drop_busy", {31'd0, busy}, 32'd0);
        rx = 1'b1;
        steps(8 * BIT_CLKS);
        en = 1'b1;
        steps(8);
        check_eq("en_drop_no_valid", {31'd0, rx_valid}, 32'd0);
        run_frame(8'h12, 1'b1, good_par(8'h12), 1'b0, vat);
        do_read();

        // parity feature: 0x07 with correct and wrong parity bit
        parity_odd = 1'b0;
        run_frame(8'h07, 1'b1, 1'b1, 1'b0, vat);
        do_read();
        run_frame(8'h07, 1'b1, 1'b0, 1'b0, vat);
        do_read();

        // randomized frames against the model
        for (int i = 0; i < 14; i++) begin
            b  = 8'($urandom);
            sb = ($urandom_range(0, 4) != 0);
            parity_odd = 1'($urandom);
            run_frame(b, sb, good_par(b) ^ ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 3) == 0), vat);
            if ($urandom_range(0, 1) == 1) do_read();
        end

        // reset mid-frame loses everything
        run_frame(8'h9E, 1'b1, good_par(8'h9E), 1'b0, vat);
        send_frame(8'h66, 1'b1, good_par(8'h66), -1, 300, vat);
        rst = 1'b0;
        steps(2);
        m_data  = '0;
        m_valid = 1'b0;
        check_eq("midrst_data", {24'd0, rx_data}, 32'd0);
        check_eq("midrst_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        rx  = 1'b1;
        rst = 1'b1;
        steps(8);
        run_frame(8'hE1, 1'b1, good_par(8'hE1), 1'b0, vat);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
